// File: rtl/i2c_write_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_write_scheduler
//
// Shares one I2C byte engine between NREQ client blocks. Each client posts a
// single-byte write (7-bit address + data byte). Clients are served in
// round-robin order. The scheduler then runs START+address, the data byte and
// STOP on the engine. A NACK causes a full re-send after a STOP, up to
// RETRY_MAX times. Every engine phase is guarded by a watchdog, and each
// client receives a completion pulse with an error flag.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   req_valid    per-client pending flag (held by the client)
//   req_addr     packed 7-bit addresses, client i at [7i+6:7i]
//   req_data     packed data bytes, client i at [8i+7:8i]
//   req_accept   one-cycle pulse: client's transaction has been latched
//   rsp_done     one-cycle pulse: client's transaction finished
//   rsp_err      qualifies rsp_done; 1 = NACK retries exhausted or timeout
//   eng_go       one-cycle command strobe to the byte engine
//   eng_cmd      0 = START+byte, 1 = byte, 2 = STOP
//   eng_byte     byte for the engine to send
//   eng_busy     engine is executing a command
//   eng_done     engine finished a command (one-cycle pulse)
//   eng_nack     slave NACK, valid together with eng_done
//   busy         scheduler is not idle
// ---------------------------------------------------------------------------
module i2c_write_scheduler #(
    parameter int NREQ           = 2,
    parameter int RETRY_MAX      = 3,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_accept,
    output logic [NREQ-1:0]     rsp_done,
    output logic                rsp_err,
    output logic                eng_go,
    output logic [1:0]          eng_cmd,
    output logic [7:0]          eng_byte,
    input  logic                eng_busy,
    input  logic                eng_done,
    input  logic                eng_nack,
    output logic                busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [31:0]   WD_LIMIT  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_BYTE  = 2'd1;
    localparam logic [1:0] CMD_STOP  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GRANT,
        S_ADDR,
        S_ADDR_W,
        S_DATA,
        S_DATA_W,
        S_STOP,
        S_STOP_W,
        S_RESP
    } state_t;

    state_t          state, state_next;

    logic [PW-1:0]   rr_ptr, rr_next;
    logic [PW-1:0]   idx, idx_next;
    logic [6:0]      addr_q, addr_next;
    logic [7:0]      data_q, data_next;
    logic [RW-1:0]   retry_cnt, retry_next;
    logic            fail, fail_next;
    logic            resend, resend_next;
    logic [31:0]     wd, wd_next;

    logic [NREQ-1:0] accept_next;
    logic [NREQ-1:0] done_next;
    logic            err_next;
    logic            go_next;
    logic [1:0]      cmd_next;
    logic [7:0]      byte_next;

    logic            found;
    int              cand;
    int              pick_i;

    // State and datapath registers. All outputs except busy are registered.
    // They are computed one cycle ahead by the next-state logic, so each
    // pulse shows up during the first cycle of the state it leads into.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            idx        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            retry_cnt  <= '0;
            fail       <= 1'b0;
            resend     <= 1'b0;
            wd         <= '0;
            req_accept <= '0;
            rsp_done   <= '0;
            rsp_err    <= 1'b0;
            eng_go     <= 1'b0;
            eng_cmd    <= '0;
            eng_byte   <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_next;
            idx        <= idx_next;
            addr_q     <= addr_next;
            data_q     <= data_next;
            retry_cnt  <= retry_next;
            fail       <= fail_next;
            resend     <= resend_next;
            wd         <= wd_next;
            req_accept <= accept_next;
            rsp_done   <= done_next;
            rsp_err    <= err_next;
            eng_go     <= go_next;
            eng_cmd    <= cmd_next;
            eng_byte   <= byte_next;
        end
    end

    // Round-robin pick: the first requester at or after rr_ptr, wrapping
    // around. This is evaluated every cycle but used only in GRANT.
    always_comb begin
        found  = 1'b0;
        cand   = 0;
        pick_i = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                pick_i = cand;
            end
        end
    end

    // Next-state logic for the transaction sequencer. The wait states share
    // the watchdog. A completing eng_done takes priority over a timeout on
    // the same cycle. After a NACK the sequencer always closes the bus with
    // a STOP. The resend flag then decides whether STOP_W loops back to ADDR
    // or finishes in RESP.
    always_comb begin
        state_next  = state;
        rr_next     = rr_ptr;
        idx_next    = idx;
        addr_next   = addr_q;
        data_next   = data_q;
        retry_next  = retry_cnt;
        fail_next   = fail;
        resend_next = resend;
        wd_next     = wd;
        accept_next = '0;
        done_next   = '0;
        err_next    = 1'b0;
        go_next     = 1'b0;
        cmd_next    = '0;
        byte_next   = '0;

        unique case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    state_next = S_GRANT;
                end
            end

            S_GRANT: begin
                if (found) begin
                    idx_next            = PW'(pick_i);
                    addr_next           = req_addr[7*pick_i +: 7];
                    data_next           = req_data[8*pick_i +: 8];
                    accept_next[pick_i] = 1'b1;
                    retry_next          = '0;
                    fail_next           = 1'b0;
                    resend_next         = 1'b0;
                    rr_next             = (PW'(pick_i) == LAST_IDX) ? '0 : PW'(pick_i + 1);
                    state_next          = S_ADDR;
                end else begin
                    state_next = S_IDLE;
                end
            end

            S_ADDR: begin
                if (!eng_busy) begin
                    go_next    = 1'b1;
                    cmd_next   = CMD_START;
                    byte_next  = {addr_q, 1'b0};
                    wd_next    = '0;
                    state_next = S_ADDR_W;
                end
            end

            S_DATA: begin
                if (!eng_busy) begin
                    go_next    = 1'b1;
                    cmd_next   = CMD_BYTE;
                    byte_next  = data_q;
                    wd_next    = '0;
                    state_next = S_DATA_W;
                end
            end

            S_STOP: begin
                if (!eng_busy) begin
                    go_next    = 1'b1;
                    cmd_next   = CMD_STOP;
                    wd_next    = '0;
                    state_next = S_STOP_W;
                end
            end

            S_ADDR_W, S_DATA_W: begin
                if (eng_done) begin
                    if (!eng_nack) begin
                        state_next = (state == S_ADDR_W) ? S_DATA : S_STOP;
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_next  = retry_cnt + RW'(1);
                        resend_next = 1'b1;
                        state_next  = S_STOP;
                    end else begin
                        fail_next   = 1'b1;
                        resend_next = 1'b0;
                        state_next  = S_STOP;
                    end
                end else if (wd == WD_LIMIT) begin
                    fail_next      = 1'b1;
                    done_next[idx] = 1'b1;
                    err_next       = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    wd_next = wd + 32'd1;
                end
            end

            S_STOP_W: begin
                if (eng_done) begin
                    if (resend) begin
                        resend_next = 1'b0;
                        state_next  = S_ADDR;
                    end else begin
                        done_next[idx] = 1'b1;
                        err_next       = fail;
                        state_next     = S_RESP;
                    end
                end else if (wd == WD_LIMIT) begin
                    fail_next      = 1'b1;
                    resend_next    = 1'b0;
                    done_next[idx] = 1'b1;
                    err_next       = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    wd_next = wd + 32'd1;
                end
            end

            S_RESP: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_scheduler
//
// Directed bench for i2c_write_scheduler with NREQ=2, RETRY_MAX=3 and
// TIMEOUT_CYCLES=50. A behavioural byte engine logs every command. It can
// NACK address phases, NACK every data phase, or withhold completion of a
// data phase. A negedge monitor collects accept and response pulses.
// ---------------------------------------------------------------------------
module tb_i2c_write_scheduler;

    localparam int NREQ      = 2;
    localparam int RETRY_MAX = 3;
    localparam int TIMEOUT   = 50;
    localparam int OP_CYCLES = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [7*NREQ-1:0] req_addr = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_accept;
    logic [NREQ-1:0]   rsp_done;
    logic              rsp_err;
    logic              eng_go;
    logic [1:0]        eng_cmd;
    logic [7:0]        eng_byte;
    logic              eng_busy = 1'b0;
    logic              eng_done = 1'b0;
    logic              eng_nack = 1'b0;
    logic              busy;

    int checkCount = 0;
    int errorCount = 0;

    i2c_write_scheduler #(
        .NREQ(NREQ),
        .RETRY_MAX(RETRY_MAX),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_accept(req_accept),
        .rsp_done(rsp_done),
        .rsp_err(rsp_err),
        .eng_go(eng_go),
        .eng_cmd(eng_cmd),
        .eng_byte(eng_byte),
        .eng_busy(eng_busy),
        .eng_done(eng_done),
        .eng_nack(eng_nack),
        .busy(busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Free-running cycle count: after posedge number N it holds N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural byte engine. A command accepted on eng_go stays busy for
    // OP_CYCLES cycles and then pulses eng_done. The test knobs select NACK
    // behaviour or withhold completion of data commands.
    logic [1:0] log_cmd[$];
    logic [7:0] log_byte[$];
    int         log_cyc[$];
    int         addr_seen = 0;
    int         nack_addr_base = 0;
    int         nack_addr_n = 0;
    bit         nack_data_all = 1'b0;
    bit         withhold_data = 1'b0;
    int         op_left = 0;
    logic [1:0] cur_cmd = '0;
    int         go_busy_viol = 0;

    always @(posedge clk) begin
        eng_done <= 1'b0;
        eng_nack <= 1'b0;
        if (rst) begin
            eng_busy <= 1'b0;
            op_left  <= 0;
        end else if (eng_go) begin
            if (eng_busy) go_busy_viol <= go_busy_viol + 1;
            log_cmd.push_back(eng_cmd);
            log_byte.push_back(eng_byte);
            log_cyc.push_back(cyc);
            cur_cmd  <= eng_cmd;
            eng_busy <= 1'b1;
            op_left  <= OP_CYCLES - 1;
            if (eng_cmd == 2'd0) addr_seen <= addr_seen + 1;
        end else if (eng_busy) begin
            if (op_left > 0) begin
                op_left <= op_left - 1;
            end else if (!(withhold_data && cur_cmd == 2'd1)) begin
                eng_busy <= 1'b0;
                eng_done <= 1'b1;
                eng_nack <= (cur_cmd == 2'd0 && (addr_seen - nack_addr_base) <= nack_addr_n) ||
                            (cur_cmd == 2'd1 && nack_data_all);
            end
        end
    end

    // Negedge monitor: records accept/response pulses and flags any pulse
    // vector that is not one-hot.
    int   acc_idx[$];
    int   acc_cyc[$];
    int   done_idx[$];
    logic done_err[$];
    int   done_cyc[$];
    int   onehot_viol = 0;

    always @(negedge clk) begin
        if ($countones(req_accept) > 1 || $countones(rsp_done) > 1) onehot_viol <= onehot_viol + 1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_accept[k]) begin
                acc_idx.push_back(k);
                acc_cyc.push_back(cyc);
            end
            if (rsp_done[k]) begin
                done_idx.push_back(k);
                done_err.push_back(rsp_err);
                done_cyc.push_back(cyc);
            end
        end
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next falling edge, clear of the active edge
    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
    endtask

    // Post a transaction for one client; it stays valid until dropped
    task automatic applyStimulus(input int client, input logic [6:0] addr, input logic [7:0] data);
        req_addr[7*client +: 7] = addr;
        req_data[8*client +: 8] = data;
        req_valid[client]       = 1'b1;
    endtask

    // Wait until a queue reaches a target size: 0 = accepts, 1 = responses,
    // 2 = engine command log. An expired budget counts as a failure.
    task automatic waitQueue(input string tag, input int which, input int target, input int budget);
        int t;
        int sz;
        t  = 0;
        sz = (which == 0) ? acc_idx.size() : (which == 1) ? done_idx.size() : log_cmd.size();
        while (sz < target && t < budget) begin
            stepCycle();
            t++;
            sz = (which == 0) ? acc_idx.size() : (which == 1) ? done_idx.size() : log_cmd.size();
        end
        checkOutput(tag, 32'(sz >= target), 32'd1);
    endtask

    function automatic logic [1:0] getCmd(input int i);
        return (i < log_cmd.size()) ? log_cmd[i] : 2'd3;
    endfunction

    function automatic logic [7:0] getByte(input int i);
        return (i < log_byte.size()) ? log_byte[i] : 8'hFF;
    endfunction

    int nl, na, nd, c0;
    int exp_retry[7] = '{0, 2, 0, 2, 0, 1, 2};

    initial begin
        // ---------------- reset state ----------------
        applyReset();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_outputs", 32'({req_accept, rsp_done, rsp_err, eng_go, eng_cmd, eng_byte}), 32'd0);

        // ---------------- single write ----------------
        nl = log_cmd.size(); na = acc_idx.size(); nd = done_idx.size();
        c0 = cyc;
        applyStimulus(0, 7'h27, 8'hA5);
        waitQueue("t1_accept_seen", 0, na + 1, 20);
        req_valid[0] = 1'b0;
        checkOutput("t1_accept_latency", 32'(acc_cyc[na] - c0), 32'd2);
        checkOutput("t1_accept_idx", 32'(acc_idx[na]), 32'd0);
        waitQueue("t1_done_seen", 1, nd + 1, 200);
        checkOutput("t1_ncmd", 32'(log_cmd.size() - nl), 32'd3);
        checkOutput("t1_cmd0", 32'(getCmd(nl)), 32'd0);
        checkOutput("t1_byte0", 32'(getByte(nl)), 32'h4E);
        checkOutput("t1_cmd1", 32'(getCmd(nl + 1)), 32'd1);
        checkOutput("t1_byte1", 32'(getByte(nl + 1)), 32'hA5);
        checkOutput("t1_cmd2", 32'(getCmd(nl + 2)), 32'd2);
        checkOutput("t1_done_idx", 32'(done_idx[nd]), 32'd0);
        checkOutput("t1_done_err", 32'(done_err[nd]), 32'd0);

        // ---------------- round robin from reset ----------------
        applyReset();
        nl = log_cmd.size(); na = acc_idx.size(); nd = done_idx.size();
        applyStimulus(0, 7'h27, 8'h5A);
        applyStimulus(1, 7'h20, 8'h11);
        waitQueue("t2_accepts_seen", 0, na + 4, 400);
        req_valid = '0;
        waitQueue("t2_dones_seen", 1, nd + 4, 400);
        repeat (10) stepCycle();
        checkOutput("t2_no_extra_accept", 32'(acc_idx.size() - na), 32'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t2_order%0d", k), 32'(acc_idx[na + k]), 32'(k % 2));
            checkOutput($sformatf("t2_start_byte%0d", k), 32'(getByte(nl + 3 * k)),
                        (k % 2 == 0) ? 32'h4E : 32'h40);
            checkOutput($sformatf("t2_err%0d", k), 32'(done_err[nd + k]), 32'd0);
        end

        // ---------------- NACK retry: two address NACKs ----------------
        nl = log_cmd.size(); na = acc_idx.size(); nd = done_idx.size();
        nack_addr_base = addr_seen;
        nack_addr_n    = 2;
        applyStimulus(0, 7'h50, 8'h33);
        waitQueue("t3_accept_seen", 0, na + 1, 20);
        req_valid[0] = 1'b0;
        waitQueue("t3_done_seen", 1, nd + 1, 400);
        nack_addr_n = 0;
        checkOutput("t3_ncmd", 32'(log_cmd.size() - nl), 32'd7);
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("t3_cmd%0d", k), 32'(getCmd(nl + k)), 32'(exp_retry[k]));
        end
        checkOutput("t3_start_byte", 32'(getByte(nl + 4)), 32'hA0);
        checkOutput("t3_data_byte", 32'(getByte(nl + 5)), 32'h33);
        checkOutput("t3_done_err", 32'(done_err[nd]), 32'd0);

        // ---------------- retry exhaustion: data always NACKed ----------------
        nl = log_cmd.size(); na = acc_idx.size(); nd = done_idx.size();
        nack_data_all = 1'b1;
        applyStimulus(1, 7'h21, 8'h77);
        waitQueue("t4_accept_seen", 0, na + 1, 20);
        req_valid[1] = 1'b0;
        waitQueue("t4_done_seen", 1, nd + 1, 800);
        nack_data_all = 1'b0;
        checkOutput("t4_ncmd", 32'(log_cmd.size() - nl), 32'd12);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("t4_cmd%0d", k), 32'(getCmd(nl + k)), 32'(k % 3));
        end
        checkOutput("t4_done_idx", 32'(done_idx[nd]), 32'd1);
        checkOutput("t4_done_err", 32'(done_err[nd]), 32'd1);

        // ---------------- timeout in DATA_W ----------------
        nl = log_cmd.size(); na = acc_idx.size(); nd = done_idx.size();
        withhold_data = 1'b1;
        applyStimulus(0, 7'h27, 8'hC3);
        waitQueue("t5_accept_seen", 0, na + 1, 20);
        req_valid[0] = 1'b0;
        waitQueue("t5_done_seen", 1, nd + 1, 300);
        checkOutput("t5_ncmd_no_stop", 32'(log_cmd.size() - nl), 32'd2);
        checkOutput("t5_cmd1", 32'(getCmd(nl + 1)), 32'd1);
        checkOutput("t5_resp_delay", 32'(done_cyc[nd] - log_cyc[nl + 1]), 32'd50);
        checkOutput("t5_done_err", 32'(done_err[nd]), 32'd1);
        withhold_data = 1'b0;
        repeat (10) stepCycle();
        checkOutput("t5_idle_after", 32'(busy), 32'd0);
        checkOutput("t5_no_stale_done", 32'(done_idx.size() - nd), 32'd1);
        nl = log_cmd.size(); na = acc_idx.size(); nd = done_idx.size();
        applyStimulus(1, 7'h22, 8'h10);
        waitQueue("t5b_accept_seen", 0, na + 1, 20);
        req_valid[1] = 1'b0;
        waitQueue("t5b_done_seen", 1, nd + 1, 200);
        checkOutput("t5b_ncmd", 32'(log_cmd.size() - nl), 32'd3);
        checkOutput("t5b_start_byte", 32'(getByte(nl)), 32'h44);
        checkOutput("t5b_done_idx", 32'(done_idx[nd]), 32'd1);
        checkOutput("t5b_done_err", 32'(done_err[nd]), 32'd0);

        // ---------------- reset mid-transaction ----------------
        nl = log_cmd.size(); na = acc_idx.size();
        withhold_data = 1'b1;
        applyStimulus(0, 7'h30, 8'h01);
        waitQueue("t6_accept_seen", 0, na + 1, 20);
        req_valid[0] = 1'b0;
        waitQueue("t6_data_issued", 2, nl + 2, 100);
        repeat (3) stepCycle();
        nd  = done_idx.size();
        rst = 1'b1;
        stepCycle();
        checkOutput("t6_busy_after_rst", 32'(busy), 32'd0);
        checkOutput("t6_outputs_after_rst",
                    32'({req_accept, rsp_done, rsp_err, eng_go, eng_cmd, eng_byte}), 32'd0);
        rst = 1'b0;
        withhold_data = 1'b0;
        repeat (30) stepCycle();
        checkOutput("t6_no_done", 32'(done_idx.size() - nd), 32'd0);
        na = acc_idx.size(); nd = done_idx.size();
        applyStimulus(0, 7'h31, 8'h02);
        applyStimulus(1, 7'h32, 8'h03);
        waitQueue("t6b_accept_seen", 0, na + 1, 20);
        req_valid = '0;
        checkOutput("t6b_first_idx", 32'(acc_idx[na]), 32'd0);
        waitQueue("t6b_done_seen", 1, nd + 1, 200);
        checkOutput("t6b_done_err", 32'(done_err[nd]), 32'd0);

        // ---------------- protocol invariants ----------------
        checkOutput("go_while_busy", 32'(go_busy_viol), 32'd0);
        checkOutput("pulses_onehot", 32'(onehot_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
